fns_ftf_encoder_iter: RTL

- Parametrised, iterative successor to the fixed 42-bit FNS crosstalk-avoidance encoder.
- Converts a binary word into a CODE_W-bit forbidden-transition-free (FTF) Fibonacci-numeral-system codeword, resolving SPC digit positions per clock.
- Uses valid/ready handshakes on both sides, so it sits between a bus-side source and the on-chip link driver and trades latency for area.

---
 rtl/fns_pkg.sv | 43 ++++
 rtl/fns_ftf_digit.sv | 25 ++
 rtl/fns_ftf_encoder_iter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fns_pkg.sv
// Shared definitions for the FNS forbidden-transition-free encoder family.
//   fns_weight(k)     : Fibonacci-style weight W[k] (W[0]=W[1]=1), 64-bit
//   fns_limit(code_w) : first out-of-range value, W[code_w+1]
//   fns_params_ok     : legality of CODE_W / SPC / DATA_W
//   fns_enc_state_t   : encoder FSM states
package fns_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fns_enc_state_t;

  function automatic logic [63:0] fns_weight(input int unsigned k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd1;
    b = 64'd1;
    for (int unsigned i = 1; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic logic [63:0] fns_limit(input int unsigned code_w);
    return fns_weight(code_w + 1);
  endfunction

  // The remainder register must hold every legal input, so 2^data_w >= limit.
  function automatic logic fns_params_ok(input int unsigned code_w,
                                         input int unsigned spc,
                                         input int unsigned data_w);
    logic ok;
    ok = (code_w >= 3) && (code_w <= 62) && (spc >= 1) && (spc <= code_w) &&
         ((code_w % spc) == 0) && (data_w >= 1) && (data_w <= 64);
    if (ok && (data_w < 64)) ok = ((64'd1 << data_w) >= fns_limit(code_w));
    return ok;
  endfunction

endpackage

// File: rtl/fns_ftf_digit.sv
// One FTF digit decision.
//   r      : remainder entering this position
//   p      : digit chosen for the next-higher position
//   wk/wk1 : weights W[k] and W[k+1]
//   digit  : resolved digit; r_next : remainder after subtracting W[k]
// Position 0 uses W[0]=W[1]=1, which reduces to digit = r[0] for r in {0,1}.
module fns_ftf_digit #(
  parameter int unsigned DATA_W = 30
) (
  input  logic [DATA_W-1:0] r,
  input  logic              p,
  input  logic [DATA_W-1:0] wk,
  input  logic [DATA_W-1:0] wk1,
  output logic              digit,
  output logic [DATA_W-1:0] r_next
);

  always_comb begin
    if (r < wk)        digit = 1'b0;
    else if (r >= wk1) digit = 1'b1;
    else               digit = p;
    r_next = digit ? (r - wk) : r;
  end

endmodule

// File: rtl/fns_ftf_encoder_iter.sv
// Iterative binary -> FTF Fibonacci-numeral-system encoder, SPC digits/cycle.
//   clock, reset_n        : clock, async active-low reset
//   in_data/valid/ready   : input word handshake
//   code_out/out_err      : codeword (MSB = position CODE_W-1), range error
//   out_valid/out_ready   : result handshake
module fns_ftf_encoder_iter
  import fns_pkg::*;
#(
  parameter int unsigned CODE_W = 42,
  parameter int unsigned SPC    = 1,
  parameter int unsigned DATA_W = 30
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned TAB_W = $clog2(CODE_W + 1);
  localparam int unsigned TAB_N = 1 << TAB_W;
  localparam logic [63:0] LIMIT = fns_limit(CODE_W);

  if (!fns_params_ok(CODE_W, SPC, DATA_W)) begin : g_bad_params
    $error("fns_ftf_encoder_iter: illegal CODE_W/SPC/DATA_W combination");
  end

  fns_enc_state_t    state_q, state_n;
  logic [DATA_W-1:0] r_q, r_n;
  logic [TAB_W-1:0]  pos_q, pos_n;
  logic              p_q, p_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [CODE_W-1:0] code_out_n;
  logic              out_err_n;

  // Constant weight table W[0..CODE_W], padded to a power of two.
  logic [DATA_W-1:0] wtab [TAB_N];
  for (genvar k = 0; k < TAB_N; k++) begin : g_wtab
    if (k <= CODE_W) begin : g_w
      assign wtab[k] = DATA_W'(fns_weight(k));
    end else begin : g_z
      assign wtab[k] = '0;
    end
  end

  // Chain of SPC digit stages covering positions pos down to pos-SPC+1.
  logic [DATA_W-1:0] r_chain [SPC+1];
  logic [SPC:0]      p_chain;
  logic [SPC-1:0]    step_bits;

  assign r_chain[0] = r_q;
  assign p_chain[0] = p_q;

  for (genvar i = 0; i < SPC; i++) begin : g_chain
    logic [TAB_W-1:0] idx;
    logic [TAB_W-1:0] idx1;
    assign idx  = pos_q - TAB_W'(i);
    assign idx1 = idx + TAB_W'(1);
    fns_ftf_digit #(.DATA_W(DATA_W)) u_digit (
      .r      (r_chain[i]),
      .p      (p_chain[i]),
      .wk     (wtab[idx]),
      .wk1    (wtab[idx1]),
      .digit  (p_chain[i+1]),
      .r_next (r_chain[i+1])
    );
    assign step_bits[SPC-1-i] = p_chain[i+1];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state_q;
    r_n        = r_q;
    pos_n      = pos_q;
    p_n        = p_q;
    code_n     = code_q;
    code_out_n = code_out;
    out_err_n  = out_err;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (64'(in_data) < LIMIT) begin
            r_n     = in_data;
            pos_n   = TAB_W'(CODE_W - 1);
            p_n     = 1'b0;
            code_n  = '0;
            state_n = RUN;
          end else begin
            code_out_n = '0;
            out_err_n  = 1'b1;
            state_n    = DONE;
          end
        end
      end
      RUN: begin
        r_n    = r_chain[SPC];
        p_n    = p_chain[SPC];
        code_n = (code_q << SPC) | CODE_W'(step_bits);
        pos_n  = pos_q - TAB_W'(SPC);
        if (pos_q == TAB_W'(SPC - 1)) begin
          code_out_n = code_n;
          out_err_n  = 1'b0;
          state_n    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          code_out_n = '0;
          out_err_n  = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      pos_q     <= '0;
      p_q       <= 1'b0;
      code_q    <= '0;
      code_out  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_n;
      r_q       <= r_n;
      pos_q     <= pos_n;
      p_q       <= p_n;
      code_q    <= code_n;
      code_out  <= code_out_n;
      out_err   <= out_err_n;
      out_valid <= (state_n == DONE);
      in_ready  <= (state_n == IDLE);
    end
  end

endmodule
